// File: rtl/sumador_pkg.sv
// sumador_pkg: shared types and configuration checks for the pipelined
// add/subtract unit.
//   sumador_op_e    : operation encoding driven on the 'sub' input.
//   sumador_cfg_ok  : elaboration-time check that WIDTH splits evenly into
//                     STAGES slices and that 1 <= STAGES <= WIDTH.
package sumador_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } sumador_op_e;

  function automatic bit sumador_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/sumador_etapa.sv
// sumador_etapa: one slice of the pipelined adder. Adds two SLICE-bit
// operands plus a carry and registers both the slice sum and the carry out
// when en is high.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : load enable (pipeline advance)
//   a, b       : slice operands (b already inverted for subtraction)
//   ci         : carry into this slice
//   s, co      : registered slice sum and carry out
module sumador_etapa #(
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0]   total_next;
  logic [SLICE-1:0] s_reg;
  logic             co_reg;

  assign total_next = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg  <= '0;
      co_reg <= 1'b0;
    end else if (en) begin
      s_reg  <= total_next[SLICE-1:0];
      co_reg <= total_next[SLICE];
    end
  end

  assign s  = s_reg;
  assign co = co_reg;

endmodule

// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined WIDTH-bit add/subtract unit split into
// STAGES carry-chained slices, one register stage per slice, with
// valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready = pipeline advance)
//   a, b, cin, sub      : operands, carry in, 0 = a+b+cin, 1 = a+~b+cin
//   out_valid/out_ready : output handshake
//   sum, cout           : result modulo 2^WIDTH and raw carry out of MSB
//   ovf                 : signed overflow, present only when SUMADOR_OVF_EN
//                         is defined
// Stage k adds slice k using the carry registered by stage k-1. Operand
// slices not yet consumed ride a skew chain; finished result slices ride a
// deskew chain so the whole word leaves the last stage together.
module sumador_segmentado
  import sumador_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SUMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE  = WIDTH / STAGES;
  localparam bit CFG_OK = sumador_cfg_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $error("sumador_segmentado: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  sumador_op_e      op;
  logic [WIDTH-1:0] b_eff;
  logic             adv;

  logic [STAGES-1:0] valid_reg;
  // [stage][slice]: operand slices still waiting for their adder, and
  // result slices already produced by earlier stages.
  logic [SLICE-1:0]  a_skew_reg [STAGES][STAGES];
  logic [SLICE-1:0]  b_skew_reg [STAGES][STAGES];
  logic [SLICE-1:0]  res_reg    [STAGES][STAGES];

  logic [SLICE-1:0]  slice_a [STAGES];
  logic [SLICE-1:0]  slice_b [STAGES];
  logic [SLICE-1:0]  slice_s [STAGES];
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] carry;

  assign op    = sumador_op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;

  // Whole pipeline moves as one; a full output stage that is not taken
  // freezes everything, bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign slice_a[gi]  = a[SLICE-1:0];
      assign slice_b[gi]  = b_eff[SLICE-1:0];
      assign carry_in[gi] = cin;
    end else begin : g_rest
      assign slice_a[gi]  = a_skew_reg[gi-1][gi];
      assign slice_b[gi]  = b_skew_reg[gi-1][gi];
      assign carry_in[gi] = carry[gi-1];
    end

    sumador_etapa #(
      .SLICE(SLICE)
    ) u_etapa (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .a    (slice_a[gi]),
      .b    (slice_b[gi]),
      .ci   (carry_in[gi]),
      .s    (slice_s[gi]),
      .co   (carry[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        for (int j = 0; j < STAGES; j++) begin
          a_skew_reg[k][j] <= '0;
          b_skew_reg[k][j] <= '0;
          res_reg[k][j]    <= '0;
        end
      end
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      for (int j = 1; j < STAGES; j++) begin
        a_skew_reg[0][j] <= a[j*SLICE +: SLICE];
        b_skew_reg[0][j] <= b_eff[j*SLICE +: SLICE];
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        for (int j = k + 1; j < STAGES; j++) begin
          a_skew_reg[k][j] <= a_skew_reg[k-1][j];
          b_skew_reg[k][j] <= b_skew_reg[k-1][j];
        end
        for (int j = 0; j < k - 1; j++) begin
          res_reg[k][j] <= res_reg[k-1][j];
        end
        res_reg[k][k-1] <= slice_s[k-1];
      end
    end
  end

  // Low slices come from the deskew chain, the top slice straight from the
  // last slice adder register.
  for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_out
    assign sum[gi*SLICE +: SLICE] = res_reg[STAGES-1][gi];
  end
  assign sum[(STAGES-1)*SLICE +: SLICE] = slice_s[STAGES-1];
  assign cout      = carry[STAGES-1];
  assign out_valid = valid_reg[STAGES-1];

`ifdef SUMADOR_OVF_EN
  // Operand sign bits ride alongside the last slice so overflow can be
  // judged against the registered sum MSB.
  logic a_msb_reg;
  logic b_msb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
    end else if (adv) begin
      a_msb_reg <= slice_a[STAGES-1][SLICE-1];
      b_msb_reg <= slice_b[STAGES-1][SLICE-1];
    end
  end

  assign ovf = (a_msb_reg == b_msb_reg) && (sum[WIDTH-1] != a_msb_reg);
`endif

endmodule

// File: tb/tb_sumador_segmentado.sv
module tb_sumador_segmentado;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic [63:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        cin, sub;
  logic        iv4, iv1, iv8;
  logic        ir4, ir1, ir8;
  logic        or4, rdy_hi;
  logic        ov4, ov1, ov8;
  logic [63:0] s4, s8;
  logic [31:0] s1;
  logic        c4, c1, c8;
  logic        o4, o1, o8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_pop4 = 0;
  int low_cnt = 0;
  bit bp_en = 1'b0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q8[$];

  vec_t v4[7];
  vec_t vbp[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumador_segmentado #(.WIDTH(64), .STAGES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(c4)
`ifdef SUMADOR_OVF_EN
    , .ovf(o4)
`endif
  );

  sumador_segmentado #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(rdy_hi), .sum(s1), .cout(c1)
`ifdef SUMADOR_OVF_EN
    , .ovf(o1)
`endif
  );

  sumador_segmentado #(.WIDTH(64), .STAGES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(rdy_hi), .sum(s8), .cout(c8)
`ifdef SUMADOR_OVF_EN
    , .ovf(o8)
`endif
  );

`ifndef SUMADOR_OVF_EN
  assign o4 = 1'b0;
  assign o1 = 1'b0;
  assign o8 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [63:0] s,
                       input logic c, input logic o, input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    $display("txn %s sum=%h cout=%b ovf=%b t=%0d", tag, s & m, c, o, cyc);
    chk({tag, "_sum"}, s & m, e.sum & m);
    chk({tag, "_cout"}, {63'd0, c}, {63'd0, e.cout});
`ifdef SUMADOR_OVF_EN
    chk({tag, "_ovf"}, {63'd0, o}, {63'd0, e.ovf});
`endif
    if (e.lat) chk({tag, "_latency"}, 64'(cyc), 64'(e.due));
  endtask

  // Monitors: one per DUT, pop and compare whenever a result is taken.
  always @(negedge clk) begin
    if (rst_n && ov4 && or4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL d4_unexpected_output actual=%h required=none", s4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        score("d4", e, s4, c4, o4, 64);
        n_pop4++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && rdy_hi) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_output actual=%h required=none", s1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        score("d1", e, {32'd0, s1}, c1, o1, 32);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8 && rdy_hi) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL d8_unexpected_output actual=%h required=none", s8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        score("d8", e, s8, c8, o8, 64);
      end
    end
  end

  always @(negedge clk) begin
    if (bp_en && rst_n && !ir4) low_cnt++;
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input int which, input vec_t v, input bit lat);
    exp_t e;
    bit   acc;
    int   n;
    a = v.a; b = v.b; sub = v.sub; cin = v.cin;
    if (which == 4) iv4 = 1'b1;
    else if (which == 1) iv1 = 1'b1;
    else iv8 = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (which == 4) ? ir4 : (which == 1) ? ir1 : ir8;
      if (acc) begin
        e.sum = v.s; e.cout = v.c; e.ovf = v.o; e.lat = lat;
        e.due = cyc + which;
        if (which == 4) q4.push_back(e);
        else if (which == 1) q1.push_back(e);
        else q8.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout_d%0d actual=not_accepted required=accepted", which);
    end
    iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(q4.size() + q1.size() + q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   base;

    v4[0] = '{64'h0123456789ABCDEF, 64'h00FFFFFFFFFFFF00, 1'b0, 1'b0, 64'h0223456789ABCCEF, 1'b0, 1'b0};
    v4[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    v4[2] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0};
    v4[3] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
    v4[4] = '{64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
    v4[5] = '{64'h8000000000000000, 64'd1, 1'b1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1};
    v4[6] = '{64'h00000000FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h0000000100000000, 1'b0, 1'b0};

    vbp[0] = '{64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0};
    vbp[1] = '{64'hFFFFFFFFFFFFFFFF, 64'd2, 1'b0, 1'b0, 64'd1, 1'b1, 1'b0};
    vbp[2] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    vbp[3] = '{64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vbp[4] = '{64'h0000FFFF0000FFFF, 64'h0000000100000001, 1'b0, 1'b0, 64'h0001000000010000, 1'b0, 1'b0};
    vbp[5] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vbp[6] = '{64'h1234, 64'h1234, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vbp[7] = '{64'h1234, 64'h1234, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};

    rst_n = 1'b0;
    iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
    or4 = 1'b1; rdy_hi = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid4", {63'd0, ov4}, 64'd0);
    chk("reset_sum4", s4, 64'd0);
    chk("reset_cout4", {63'd0, c4}, 64'd0);
    chk("reset_out_valid8", {63'd0, ov8}, 64'd0);
    chk("reset_out_valid1", {63'd0, ov1}, 64'd0);
`ifdef SUMADOR_OVF_EN
    chk("reset_ovf4", {63'd0, o4}, 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready4", {63'd0, ir4}, 64'd1);

    // Directed vectors, back to back, no stall.
    for (int i = 0; i < 7; i++) send(4, v4[i], 1'b1);
    drain();

    // Other geometries: 32-bit single stage and 64-bit eight stages.
    v = '{64'h0123456789ABCDEF, 64'h00FFFFFFFFFFFF00, 1'b0, 1'b0, 64'h0000000089ABCCEF, 1'b1, 1'b0};
    send(1, v, 1'b1);
    v = '{64'd5, 64'd7, 1'b1, 1'b1, 64'h00000000FFFFFFFE, 1'b0, 1'b0};
    send(1, v, 1'b1);
    send(8, v4[0], 1'b1);
    send(8, v4[1], 1'b1);
    drain();

    // Back-pressure: 8 beats with a 3-cycle output stall mid-stream.
    base = n_pop4;
    low_cnt = 0;
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(4, vbp[i], 1'b0);
      end
      begin
        int n;
        n = 0;
        while (n_pop4 < base + 2 && n < 100) begin
          @(posedge clk);
          n++;
        end
        #1;
        or4 = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {63'd0, ir4}, 64'd0);
          chk("stall_out_valid", {63'd0, ov4}, 64'd1);
          if (q4.size() != 0) begin
            chk("stall_sum_held", s4, q4[0].sum);
            chk("stall_cout_held", {63'd0, c4}, {63'd0, q4[0].cout});
          end else begin
            checks++; errors++;
            $display("FAIL stall_queue actual=empty required=pending");
          end
        end
        @(posedge clk);
        #1;
        or4 = 1'b1;
      end
    join
    drain();
    bp_en = 1'b0;
    chk("bp_in_ready_low_cycles", 64'(low_cnt), 64'd3);
    chk("bp_results_taken", 64'(n_pop4 - base), 64'd8);

    // Reset with three beats in flight, the oldest at the output.
    or4 = 1'b0;
    for (int i = 0; i < 3; i++) send(4, v4[i], 1'b0);
    @(posedge clk);
    #1;
    chk("prereset_out_valid", {63'd0, ov4}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, ov4}, 64'd0);
    chk("midreset_sum", s4, 64'd0);
    chk("midreset_cout", {63'd0, c4}, 64'd0);
    q4.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or4 = 1'b1;
    #1;
    chk("postreset_in_ready", {63'd0, ir4}, 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("postreset_no_stale", {63'd0, ov4}, 64'd0);
    send(4, v4[4], 1'b1);
    send(4, v4[3], 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
